// File: rtl/sync_min_search.sv
// Sweeps the difference memory once per diff_done edge and keeps the smallest of the first DIFF_ITER_LIMIT words.
// Latency 2^LOG2_DIFF_DEPTH+2 cycles edge-to-sync_valid; no backpressure, upstream must return data the cycle after each read.
module sync_min_search #(
  parameter int DATA_W          = 16,
  parameter int LOG2_DIFF_DEPTH = 5,
  parameter int DIFF_ITER_LIMIT = 17,
  parameter int DIFF_RESOLUTION = 50,
  parameter int OFFSET_W        = 10
) (
  input  logic                       clk,
  input  logic                       reset_s,
  input  logic                       diff_done,
  input  logic                       search_clr,
  input  logic [2*DATA_W-1:0]        diff_data_i,
  output logic                       diff_r_mem_en,
  output logic [2*DATA_W-1:0]        min_val,
  output logic [LOG2_DIFF_DEPTH-1:0] min_idx,
  output logic [OFFSET_W-1:0]        sync_offset,
  output logic                       sync_valid,
  output logic                       search_done
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_e;

  localparam logic [LOG2_DIFF_DEPTH-1:0] LAST_RD = '1;

  state_e                       state_q, state_d;
  logic                         diff_done_q;
  logic [LOG2_DIFF_DEPTH-1:0]   rd_cnt_q, rd_cnt_d;
  logic [LOG2_DIFF_DEPTH-1:0]   cmp_idx_q;
  logic                         cmp_vld_q;
  logic [2*DATA_W-1:0]          min_val_q, min_val_d;
  logic [LOG2_DIFF_DEPTH-1:0]   min_idx_q, min_idx_d;
  logic [OFFSET_W-1:0]          sync_offset_q, sync_offset_d;
  logic                         sync_valid_q;
  logic                         start_evt;
  logic                         upd;

  assign start_evt = (state_q == IDLE) && diff_done && !diff_done_q;

  always_ff @(posedge clk) begin
    if (reset_s) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_evt) state_d = READ;
      READ:    if (rd_cnt_q == LAST_RD) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    if (search_clr) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    diff_r_mem_en = (state_q == READ);
    search_done   = (state_q == DONE);
  end

  // Compare stage runs one cycle behind the read issue, aligned with returning data.
  assign upd = cmp_vld_q
            && (32'(cmp_idx_q) < DIFF_ITER_LIMIT)
            && (diff_data_i < min_val_q);

  always_comb begin
    rd_cnt_d      = rd_cnt_q;
    min_val_d     = min_val_q;
    min_idx_d     = min_idx_q;
    sync_offset_d = sync_offset_q;
    if (start_evt) begin
      rd_cnt_d  = '0;
      min_val_d = '1;
      min_idx_d = '0;
    end else begin
      if (state_q == READ) rd_cnt_d = rd_cnt_q + 1'b1;
      if (upd) begin
        min_val_d = diff_data_i;
        min_idx_d = cmp_idx_q;
      end
    end
    // Use the next-state index so a final-cycle update is reflected in the offset.
    if (state_q == DRAIN) sync_offset_d = OFFSET_W'(32'(min_idx_d) * 32'(DIFF_RESOLUTION));
  end

  always_ff @(posedge clk) begin
    if (reset_s) begin
      diff_done_q   <= 1'b0;
      rd_cnt_q      <= '0;
      cmp_idx_q     <= '0;
      cmp_vld_q     <= 1'b0;
      min_val_q     <= '1;
      min_idx_q     <= '0;
      sync_offset_q <= '0;
      sync_valid_q  <= 1'b0;
    end else begin
      diff_done_q   <= diff_done;
      rd_cnt_q      <= rd_cnt_d;
      cmp_idx_q     <= rd_cnt_q;
      cmp_vld_q     <= diff_r_mem_en;
      min_val_q     <= min_val_d;
      min_idx_q     <= min_idx_d;
      sync_offset_q <= sync_offset_d;
      sync_valid_q  <= (state_q == DRAIN);
    end
  end

  assign min_val     = min_val_q;
  assign min_idx     = min_idx_q;
  assign sync_offset = sync_offset_q;
  assign sync_valid  = sync_valid_q;

endmodule

// File: tb/tb_sync_min_search.sv
// Bench for sync_min_search: upstream memory model plus argmin reference over the evaluated window.
module tb_sync_min_search;
  localparam int DW    = 16;
  localparam int L     = 5;
  localparam int LIMIT = 17;
  localparam int RES   = 50;
  localparam int OW    = 10;
  localparam int DEPTH = 32;

  logic            clk = 1'b0;
  logic            reset_s;
  logic            diff_done;
  logic            search_clr;
  logic [2*DW-1:0] diff_data_i;
  logic            diff_r_mem_en;
  logic [2*DW-1:0] min_val;
  logic [L-1:0]    min_idx;
  logic [OW-1:0]   sync_offset;
  logic            sync_valid;
  logic            search_done;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  sync_min_search #(
    .DATA_W(DW), .LOG2_DIFF_DEPTH(L), .DIFF_ITER_LIMIT(LIMIT),
    .DIFF_RESOLUTION(RES), .OFFSET_W(OW)
  ) dut (
    .clk(clk), .reset_s(reset_s), .diff_done(diff_done), .search_clr(search_clr),
    .diff_data_i(diff_data_i), .diff_r_mem_en(diff_r_mem_en), .min_val(min_val),
    .min_idx(min_idx), .sync_offset(sync_offset), .sync_valid(sync_valid),
    .search_done(search_done)
  );

  // Upstream difference memory: registered read, post-incrementing address, reset with the system.
  logic [31:0]  mem [DEPTH];
  logic [L-1:0] up_ptr;
  int unsigned  en_total = 0;

  always @(posedge clk) begin
    if (reset_s) begin
      up_ptr      <= '0;
      diff_data_i <= '0;
    end else if (diff_r_mem_en) begin
      diff_data_i <= mem[up_ptr];
      up_ptr      <= up_ptr + 1'b1;
      en_total    <= en_total + 1;
    end
  end

  // Argmin over the evaluated window: first index whose value no other entry beats or ties earlier.
  function automatic logic [L-1:0] ref_idx();
    bit best;
    for (int i = 0; i < LIMIT; i++) begin
      best = 1'b1;
      for (int j = 0; j < LIMIT; j++)
        if (mem[j] < mem[i] || (j < i && mem[j] == mem[i])) best = 1'b0;
      if (best) return L'(i);
    end
    return '0;
  endfunction

  task automatic run_search(input string name, input bit raise, input int clr_at, input bit keep_high);
    int            cyc;
    int unsigned   en0;
    logic [L-1:0]  ptr0;
    logic [L-1:0]  e_idx;
    logic [31:0]   e_val;
    logic [OW-1:0] e_off;
    e_idx = ref_idx();
    e_val = mem[e_idx];
    e_off = OW'(32'(e_idx) * RES);
    en0   = en_total;
    ptr0  = up_ptr;
    if (raise) diff_done = 1'b1;
    cyc = 0;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      search_clr = (cyc == clr_at);
      if (sync_valid) break;
    end
    search_clr = 1'b0;
    n_checks++; if (ptr0 !== '0) $display("FAIL %s start_ptr: got %0d want 0", name, ptr0); else n_pass++;
    n_checks++; if (cyc !== 34) $display("FAIL %s latency: got %0d want 34", name, cyc); else n_pass++;
    n_checks++; if (min_idx !== e_idx) $display("FAIL %s min_idx: got %0d want %0d", name, min_idx, e_idx); else n_pass++;
    n_checks++; if (min_val !== e_val) $display("FAIL %s min_val: got %0h want %0h", name, min_val, e_val); else n_pass++;
    n_checks++; if (sync_offset !== e_off) $display("FAIL %s sync_offset: got %0d want %0d", name, sync_offset, e_off); else n_pass++;
    n_checks++; if (search_done !== 1'b1) $display("FAIL %s search_done: got %b want 1", name, search_done); else n_pass++;
    n_checks++; if (en_total - en0 !== 32) $display("FAIL %s read_count: got %0d want 32", name, en_total - en0); else n_pass++;
    @(negedge clk);
    n_checks++; if (sync_valid !== 1'b0) $display("FAIL %s sync_valid_pulse: got %b want 0", name, sync_valid); else n_pass++;
    n_checks++; if (search_done !== 1'b1) $display("FAIL %s done_hold: got %b want 1", name, search_done); else n_pass++;
    search_clr = 1'b1;
    @(negedge clk);
    search_clr = 1'b0;
    n_checks++; if (search_done !== 1'b0) $display("FAIL %s clr_done: got %b want 0", name, search_done); else n_pass++;
    n_checks++; if (min_idx !== e_idx) $display("FAIL %s idx_hold: got %0d want %0d", name, min_idx, e_idx); else n_pass++;
    if (!keep_high) diff_done = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_s = 1'b1; diff_done = 1'b0; search_clr = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (diff_r_mem_en !== 1'b0) $display("FAIL reset en: got %b want 0", diff_r_mem_en); else n_pass++;
    n_checks++; if (min_val !== '1) $display("FAIL reset min_val: got %0h want ffffffff", min_val); else n_pass++;
    n_checks++; if (min_idx !== '0) $display("FAIL reset min_idx: got %0d want 0", min_idx); else n_pass++;
    n_checks++; if (sync_offset !== '0) $display("FAIL reset sync_offset: got %0d want 0", sync_offset); else n_pass++;
    n_checks++; if (sync_valid !== 1'b0) $display("FAIL reset sync_valid: got %b want 0", sync_valid); else n_pass++;
    n_checks++; if (search_done !== 1'b0) $display("FAIL reset search_done: got %b want 0", search_done); else n_pass++;
    reset_s = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_ramp();
    for (int k = 0; k < DEPTH; k++) mem[k] = (k < LIMIT) ? 32'(1000 - 10 * k) : 32'd0;
    run_search("ramp", 1'b1, 0, 1'b0);
  endtask

  task automatic test_tie();
    for (int k = 0; k < DEPTH; k++) mem[k] = 32'd100;
    mem[3] = 32'd5; mem[9] = 32'd5;
    run_search("tie", 1'b1, 0, 1'b0);
  endtask

  task automatic test_all_ones();
    for (int k = 0; k < DEPTH; k++) mem[k] = '1;
    run_search("all_ones", 1'b1, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      for (int k = 0; k < DEPTH; k++)
        mem[k] = (it % 2 == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      if (it == 3) mem[LIMIT] = 32'd0;
      run_search("random", 1'b1, 0, 1'b0);
    end
  endtask

  task automatic test_held_high();
    int sv_cnt;
    int unsigned en0;
    for (int k = 0; k < DEPTH; k++) mem[k] = 32'($urandom_range(10, 5000));
    reset_s = 1'b1; diff_done = 1'b1;
    repeat (2) @(negedge clk);
    reset_s = 1'b0;
    run_search("held_high", 1'b0, 0, 1'b1);
    sv_cnt = 0; en0 = en_total;
    repeat (40) begin
      @(negedge clk);
      if (sync_valid || search_done) sv_cnt++;
    end
    n_checks++; if (en_total - en0 !== 0) $display("FAIL held_high retrigger_reads: got %0d want 0", en_total - en0); else n_pass++;
    n_checks++; if (sv_cnt !== 0) $display("FAIL held_high retrigger_done: got %0d want 0", sv_cnt); else n_pass++;
    diff_done = 1'b0;
    @(negedge clk);
    for (int k = 0; k < DEPTH; k++) mem[k] = 32'($urandom_range(10, 5000));
    run_search("rearm", 1'b1, 0, 1'b0);
  endtask

  task automatic test_reset_mid();
    int sv_cnt;
    int unsigned en0;
    for (int k = 0; k < DEPTH; k++) mem[k] = 32'($urandom_range(100, 900));
    mem[0] = 32'd7;
    diff_done = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++; if (min_val !== 32'd7) $display("FAIL reset_mid pre_min: got %0d want 7", min_val); else n_pass++;
    reset_s = 1'b1; diff_done = 1'b0;
    @(negedge clk);
    n_checks++; if (diff_r_mem_en !== 1'b0) $display("FAIL reset_mid en: got %b want 0", diff_r_mem_en); else n_pass++;
    n_checks++; if (min_val !== '1) $display("FAIL reset_mid min_val: got %0h want ffffffff", min_val); else n_pass++;
    n_checks++; if (min_idx !== '0) $display("FAIL reset_mid min_idx: got %0d want 0", min_idx); else n_pass++;
    n_checks++; if (sync_offset !== '0) $display("FAIL reset_mid sync_offset: got %0d want 0", sync_offset); else n_pass++;
    n_checks++; if (search_done !== 1'b0) $display("FAIL reset_mid search_done: got %b want 0", search_done); else n_pass++;
    reset_s = 1'b0;
    sv_cnt = 0; en0 = en_total;
    repeat (50) begin
      @(negedge clk);
      if (sync_valid) sv_cnt++;
    end
    n_checks++; if (sv_cnt !== 0) $display("FAIL reset_mid stray_valid: got %0d want 0", sv_cnt); else n_pass++;
    n_checks++; if (en_total - en0 !== 0) $display("FAIL reset_mid stray_reads: got %0d want 0", en_total - en0); else n_pass++;
    run_search("after_reset", 1'b1, 0, 1'b0);
  endtask

  task automatic test_clr_during_read();
    for (int k = 0; k < DEPTH; k++) mem[k] = $urandom;
    run_search("clr_in_read", 1'b1, 5, 1'b0);
  endtask

  initial begin
    reset_s = 1'b1; diff_done = 1'b0; search_clr = 1'b0;
    for (int k = 0; k < DEPTH; k++) mem[k] = '0;
    test_reset();
    test_ramp();
    test_tie();
    test_all_ones();
    test_random();
    test_held_high();
    test_reset_mid();
    test_clr_during_read();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/sync_min_search.md
# sync_min_search

Downstream stage of the template-difference engine. Once the difference memory is filled (`diff_done`), it sweeps the full difference memory through the upstream read port and finds the smallest accumulated absolute difference among the first `DIFF_ITER_LIMIT` entries. It reports that entry's index and value, and the sample offset of the best template alignment (index × `DIFF_RESOLUTION`), which the feature extractor uses as its beat sync point.

## Interface
Parameters:
- `DATA_W`, 16, sample width; difference words are `2*DATA_W` bits
- `LOG2_DIFF_DEPTH`, 5, difference memory address width; depth = 2^`LOG2_DIFF_DEPTH`
- `DIFF_ITER_LIMIT`, 17, number of valid entries evaluated (indices 0..`DIFF_ITER_LIMIT`-1)
- `DIFF_RESOLUTION`, 50, samples per difference step
- `OFFSET_W`, 10, width of `sync_offset`

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `reset_s`  in  1  synchronous, active-high reset
- `diff_done`  in  1  upstream level: difference memory filled
- `search_clr`  in  1  one-cycle pulse; re-arms the block after a search
- `diff_data_i`  in  2*DATA_W  upstream memory read data; valid the cycle after `diff_r_mem_en`
- `diff_r_mem_en`  out  1  upstream read enable; upstream read address post-increments on each asserted cycle
- `min_val`  out  2*DATA_W  smallest evaluated difference (unsigned)
- `min_idx`  out  LOG2_DIFF_DEPTH  index of `min_val`
- `sync_offset`  out  OFFSET_W  `min_idx * DIFF_RESOLUTION`, truncated to `OFFSET_W`
- `sync_valid`  out  1  one-cycle pulse when the result is final
- `search_done`  out  1  level; high from the `sync_valid` cycle until `search_clr`

## Operation
- Reset values: `diff_r_mem_en`=0, `min_val`=all ones, `min_idx`=0, `sync_offset`=0, `sync_valid`=0, `search_done`=0. FSM enters IDLE and the edge register `diff_done_q` clears to 0.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE: waits for a rising edge of `diff_done` (`diff_done & ~diff_done_q`). On the edge: load `min_val`=all ones and `min_idx`=0, clear `rd_cnt`, go to READ. A level held high out of reset counts as an edge.
- READ: `diff_r_mem_en`=1 (registered, equals state==READ). Issues exactly 2^`LOG2_DIFF_DEPTH` reads, so the upstream read pointer wraps back to 0 for the next frame. `rd_cnt` increments each cycle. After the last read, go to DRAIN.
- Compare path: `rd_cnt` and the enable are delayed one cycle to form `cmp_idx` and `cmp_vld`.
- Update rule: if `cmp_vld`, `cmp_idx < DIFF_ITER_LIMIT`, and `diff_data_i < min_val` (unsigned, strict), then `min_val` ← `diff_data_i` and `min_idx` ← `cmp_idx`.
- Ties keep the lowest index. Entries at or above `DIFF_ITER_LIMIT` are read and discarded.
- DRAIN: one cycle so the final read data is consumed. Then go to DONE and register `sync_offset` from the final `min_idx`.
- DONE: `sync_valid` is high on entry only. `search_done` stays high and outputs hold. `search_clr` returns the FSM to IDLE and clears `search_done`; outputs keep their values until the next search starts.
- `search_clr` outside DONE is ignored. `diff_done` falling or re-rising during READ/DRAIN is ignored. `diff_done` still high at `search_clr` does not retrigger; a new rising edge is required.
- `reset_s` mid-search: immediate return to reset values on the next edge. `diff_r_mem_en` drops the following cycle. Upstream pointer alignment requires upstream reset in the same event (system reset).
- If all evaluated entries equal all ones, the result is `min_idx`=0 and `min_val`=all ones.

## Timing
- Cycle 0: FSM samples the `diff_done` edge.
- Cycles 1..2^`LOG2_DIFF_DEPTH` (1..32 at default): `diff_r_mem_en`=1.
- Data for index k is present in cycle k+2 and compared at the end of that cycle.
- Cycle 33: DRAIN; index 31 data is discarded.
- Cycle 34: DONE, `sync_valid`=1, `search_done`=1, `sync_offset` valid.
- Latency from `diff_done` edge to `sync_valid` is 2^`LOG2_DIFF_DEPTH`+2 cycles.
- Minimum re-arm: `search_clr` in any DONE cycle; IDLE from the next cycle.

## Test plan
- Entries k=0..16 hold 1000-10·k, entries 17..31 hold 0; raise `diff_done` -> `sync_valid` at cycle 34, `min_idx`=16, `min_val`=840, `sync_offset`=800.
- Entries 3 and 9 both hold 5, all others 100 -> `min_idx`=3, `sync_offset`=150.
- All entries 0xFFFFFFFF -> `min_idx`=0, `min_val`=0xFFFFFFFF; exactly 32 `diff_r_mem_en` cycles counted.
- `diff_done` held high after reset, completed search, `search_clr` -> `search_done`=0 and no new search. Drop then raise `diff_done` -> second search; upstream read address starts at 0 again.
- `reset_s` in cycle 10 of READ -> next cycle all outputs at reset values and `diff_r_mem_en`=0; no `sync_valid` without a new edge.
- `search_clr` pulsed during READ -> ignored; `sync_valid` still at cycle 34.
